// File: rtl/ubr_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : ubr_operand_stage_if
//  Purpose  : Bundles the instruction, memory-read, operand, result and
//             memory-write signals of the UBR operand stage.
//  Modports : slave  - the operand stage itself
//             master - the environment (decoder, memory, compute unit)
//  Revision : 1.0 - initial release
// ============================================================================
interface ubr_operand_stage_if #(
    parameter int ROW_W  = 64,
    parameter int ADDR_W = 8
) ();
    logic                  instr_valid;
    logic                  instr_ready;
    logic [4:0]            ubr_flags;
    logic [5*ADDR_W-1:0]   op_addr;
    logic                  mem_rd_req;
    logic [ADDR_W-1:0]     mem_rd_addr;
    logic                  mem_rd_valid;
    logic [ROW_W-1:0]      mem_rd_data;
    logic                  opnd_valid;
    logic                  opnd_ready;
    logic [ROW_W-1:0]      opnd_src1;
    logic [ROW_W-1:0]      opnd_src2;
    logic [ROW_W-1:0]      opnd_iw1;
    logic [ROW_W-1:0]      opnd_iw2;
    logic                  res_valid;
    logic [ROW_W-1:0]      res_data;
    logic                  mem_wr_en;
    logic [ADDR_W-1:0]     mem_wr_addr;
    logic [ROW_W-1:0]      mem_wr_data;
    logic                  done;

    modport slave (
        input  instr_valid, ubr_flags, op_addr, mem_rd_valid, mem_rd_data,
               opnd_ready, res_valid, res_data,
        output instr_ready, mem_rd_req, mem_rd_addr, opnd_valid,
               opnd_src1, opnd_src2, opnd_iw1, opnd_iw2,
               mem_wr_en, mem_wr_addr, mem_wr_data, done
    );

    modport master (
        output instr_valid, ubr_flags, op_addr, mem_rd_valid, mem_rd_data,
               opnd_ready, res_valid, res_data,
        input  instr_ready, mem_rd_req, mem_rd_addr, opnd_valid,
               opnd_src1, opnd_src2, opnd_iw1, opnd_iw2,
               mem_wr_en, mem_wr_addr, mem_wr_data, done
    );
endinterface
`default_nettype wire

// File: rtl/ubr_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ubr_operand_stage
//  Purpose  : Sources the four operand rows of an instruction either from
//             their use-buffer registers or from crossbar row reads, hands
//             them to the compute unit, then stores the result in the dest
//             buffer and optionally writes it back to memory.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - ubr_operand_stage_if.slave (instruction accept,
//                     memory read, operand handshake, result, memory write,
//                     done pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module ubr_operand_stage #(
    parameter int ROW_W  = 64,
    parameter int ADDR_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ubr_operand_stage_if.slave    bus
);

    // Slot numbering follows the flag/address packing: 0=dest, 1=src1,
    // 2=src2, 3=iw1, 4=iw2.
    localparam int c_NUM_SLOTS = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_WB       = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [4:0]         r_flags;
    logic [ADDR_W-1:0]  r_addr [c_NUM_SLOTS];
    logic [ROW_W-1:0]   r_buf  [c_NUM_SLOTS];
    logic [1:0]         r_ptr;      // 0..3 walks src1..iw2
    logic               r_rd_done;  // read data captured, slot retires next cycle
    logic               r_done;

    logic [2:0]         w_slot;
    logic               w_accept;
    logic               w_rd_req;
    logic               w_rd_hit;
    logic               w_adv;
    logic               w_res_hit;
    logic               w_done_nx;

    assign w_slot = {1'b0, r_ptr} + 3'd1;

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_rd_req   = 1'b0;
        w_adv      = 1'b0;
        w_res_hit  = 1'b0;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A buffered slot costs one cycle; a read slot holds the
                // request until data arrives, then spends one more cycle
                // with the request dropped before moving on.
                if (r_flags[w_slot] || r_rd_done) begin
                    w_adv = 1'b1;
                end else begin
                    w_rd_req = 1'b1;
                end
                if (w_adv && (r_ptr == 2'd3)) begin
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.opnd_ready) begin
                    w_state_nx = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (bus.res_valid) begin
                    w_res_hit = 1'b1;
                    if (r_flags[0]) begin
                        w_state_nx = ST_IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_state_nx = ST_IDLE;
                w_done_nx  = 1'b1;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Read data is only taken while a request is actually outstanding.
    assign w_rd_hit = w_rd_req && bus.mem_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_flags   <= '0;
            r_ptr     <= '0;
            r_rd_done <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < c_NUM_SLOTS; i++) begin
                r_addr[i] <= '0;
                r_buf[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nx;
            r_done  <= w_done_nx;
            if (w_accept) begin
                r_flags   <= bus.ubr_flags;
                r_ptr     <= '0;
                r_rd_done <= 1'b0;
                for (int i = 0; i < c_NUM_SLOTS; i++) begin
                    r_addr[i] <= bus.op_addr[i*ADDR_W +: ADDR_W];
                end
            end
            if (w_rd_hit) begin
                r_buf[w_slot] <= bus.mem_rd_data;
                r_rd_done     <= 1'b1;
            end
            if (w_adv) begin
                r_ptr     <= r_ptr + 2'd1;
                r_rd_done <= 1'b0;
            end
            if (w_res_hit) begin
                r_buf[0] <= bus.res_data;
            end
        end
    end

    assign bus.instr_ready = (r_state == ST_IDLE);
    assign bus.mem_rd_req  = w_rd_req;
    assign bus.mem_rd_addr = w_rd_req ? r_addr[w_slot] : '0;
    assign bus.opnd_valid  = (r_state == ST_ISSUE);
    assign bus.opnd_src1   = r_buf[1];
    assign bus.opnd_src2   = r_buf[2];
    assign bus.opnd_iw1    = r_buf[3];
    assign bus.opnd_iw2    = r_buf[4];
    assign bus.mem_wr_en   = (r_state == ST_WB);
    assign bus.mem_wr_addr = (r_state == ST_WB) ? r_addr[0] : '0;
    assign bus.mem_wr_data = (r_state == ST_WB) ? r_buf[0]  : '0;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ubr_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ubr_operand_stage
//  Purpose  : Self-checking bench for ubr_operand_stage. A row memory and a
//             compute-unit stand-in drive the stage; a slot-level model of
//             the use buffers predicts reads, operands, latency and writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ubr_operand_stage;

    localparam int ROW_W  = 64;
    localparam int ADDR_W = 8;

    logic clk;
    logic rst_n;

    ubr_operand_stage_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

    ubr_operand_stage #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mem   [256];
    logic [63:0] m_buf [5];     // model of the five use buffers
    logic [7:0]  rd_log [$];    // addresses requested by the stage
    int          lat_sum;       // sum of (latency+1) over reads served
    int          lat_fix = 2;   // <0 means random 0..3
    bit          resp_en = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Row memory: answers a held request after a chosen latency.
    initial begin : mem_resp
        bit pend;
        int cnt;
        pend = 1'b0;
        cnt  = 0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                bus.mem_rd_valid = 1'b0;
                if (rst_n && bus.mem_rd_req) begin
                    if (!pend) begin
                        pend = 1'b1;
                        cnt  = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
                        rd_log.push_back(bus.mem_rd_addr);
                        lat_sum += cnt + 1;
                    end
                    if (cnt == 0) begin
                        bus.mem_rd_valid = 1'b1;
                        bus.mem_rd_data  = mem[bus.mem_rd_addr];
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    task automatic run_instr(input logic [4:0] flags, input logic [39:0] addrs,
                             input logic [63:0] res, input int hold, input bit spur);
        logic [7:0] exp_rd [$];
        int         cyc;
        int         wr_cnt;
        bit         done_seen;
        logic [7:0] wr_addr;
        logic [63:0] wr_data;
        logic [63:0] junk;

        // Model: each clear-flag slot reads memory in slot order and refreshes its buffer.
        for (int s = 1; s < 5; s++) begin
            if (!flags[s]) begin
                exp_rd.push_back(addrs[s*8 +: 8]);
                m_buf[s] = mem[addrs[s*8 +: 8]];
            end
        end
        rd_log.delete();
        lat_sum = 0;

        @(negedge clk);
        chk("instr_ready_idle", bus.instr_ready, 1'b1);
        bus.instr_valid = 1'b1;
        bus.ubr_flags   = flags;
        bus.op_addr     = addrs;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.opnd_valid && cyc < 200);
        chk("opnd_valid_seen", bus.opnd_valid, 1'b1);
        chk("issue_latency", 64'(cyc), 64'(5 + lat_sum));
        chk("instr_ready_busy", bus.instr_ready, 1'b0);
        chk("read_count", 64'(rd_log.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) begin
            chk("read_addr", rd_log[i], exp_rd[i]);
        end

        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", bus.opnd_valid, 1'b1);
            chk("hold_src1", bus.opnd_src1, m_buf[1]);
            chk("hold_iw2", bus.opnd_iw2, m_buf[4]);
            if (spur && h == hold / 2) begin
                junk = {$urandom, $urandom};
                #2;
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = junk;
            end
            @(negedge clk);
        end
        chk("opnd_src1", bus.opnd_src1, m_buf[1]);
        chk("opnd_src2", bus.opnd_src2, m_buf[2]);
        chk("opnd_iw1", bus.opnd_iw1, m_buf[3]);
        chk("opnd_iw2", bus.opnd_iw2, m_buf[4]);
        bus.opnd_ready = 1'b1;
        @(negedge clk);
        bus.opnd_ready = 1'b0;
        chk("opnd_valid_drop", bus.opnd_valid, 1'b0);

        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_data  = res;
        m_buf[0]      = res;
        @(negedge clk);
        bus.res_valid = 1'b0;

        wr_cnt    = 0;
        done_seen = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        for (int k = 0; k < 8; k++) begin
            if (bus.mem_wr_en) begin
                wr_cnt++;
                wr_addr = bus.mem_wr_addr;
                wr_data = bus.mem_wr_data;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                chk("ready_at_done", bus.instr_ready, 1'b1);
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", done_seen, 1'b1);
        chk("write_count", 64'(wr_cnt), flags[0] ? 64'd0 : 64'd1);
        if (!flags[0]) begin
            chk("write_addr", wr_addr, addrs[7:0]);
            chk("write_data", wr_data, m_buf[0]);
        end
        @(negedge clk);
        chk("done_one_cycle", bus.done, 1'b0);
    endtask

    initial begin : main
        logic [39:0] a;
        logic [4:0]  f;
        logic [63:0] r;

        rst_n            = 1'b0;
        bus.instr_valid  = 1'b0;
        bus.ubr_flags    = '0;
        bus.op_addr      = '0;
        bus.opnd_ready   = 1'b0;
        bus.res_valid    = 1'b0;
        bus.res_data     = '0;
        for (int i = 0; i < 256; i++) mem[i] = 64'(i) + 64'h100;
        for (int i = 0; i < 5; i++) m_buf[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_instr_ready", bus.instr_ready, 1'b1);
        chk("rst_rd_req", bus.mem_rd_req, 1'b0);
        chk("rst_opnd_valid", bus.opnd_valid, 1'b0);
        chk("rst_wr_en", bus.mem_wr_en, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_src1", bus.opnd_src1, 64'h0);
        rst_n = 1'b1;

        // All slots read, 2-cycle memory, result written to 0x20.
        lat_fix = 2;
        run_instr(5'b00000, {8'd4, 8'd3, 8'd2, 8'd1, 8'h20}, 64'hDEAD, 0, 1'b0);
        // All operands buffered, different addresses must not matter.
        run_instr(5'b11110, {8'd40, 8'd30, 8'd20, 8'd10, 8'h20}, 64'hDEAD, 0, 1'b0);
        // Dest flag set: no write.
        run_instr(5'b11111, {8'd4, 8'd3, 8'd2, 8'd1, 8'h20}, 64'hDEAD, 0, 1'b0);
        // Only src2 buffered; long operand stall with a stray read strobe.
        run_instr(5'b00100, {8'd8, 8'd7, 8'd6, 8'd5, 8'h21}, 64'hBEEF, 10, 1'b1);

        // Randomized traffic over random memory contents and latencies.
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        lat_fix = -1;
        for (int n = 0; n < 24; n++) begin
            a[31:0]  = $urandom;
            a[39:32] = 8'($urandom);
            f        = 5'($urandom);
            r        = {$urandom, $urandom};
            run_instr(f, a, r, int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Reset while src1 read is outstanding; the late strobe must be dropped.
        resp_en = 1'b0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.ubr_flags   = 5'b11101;
        bus.op_addr     = {8'd0, 8'd0, 8'd0, 8'h33, 8'h0};
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_rd_req", bus.mem_rd_req, 1'b1);
        chk("pre_rst_rd_addr", bus.mem_rd_addr, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.instr_ready, 1'b1);
        chk("mid_rst_rd_req", bus.mem_rd_req, 1'b0);
        chk("mid_rst_opnd_valid", bus.opnd_valid, 1'b0);
        chk("mid_rst_src1", bus.opnd_src1, 64'h0);
        chk("mid_rst_iw2", bus.opnd_iw2, 64'h0);
        chk("mid_rst_wr_en", bus.mem_wr_en, 1'b0);
        chk("mid_rst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        bus.mem_rd_valid = 1'b0;
        for (int i = 0; i < 5; i++) m_buf[i] = '0;
        resp_en = 1'b1;
        run_instr(5'b11111, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 64'h1234, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
